// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_t;

    localparam int DEF_TICKS_PER_MS = 1000;
    localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled clk cycles and emits a registered tick
// plus a same-cycle carry so the owner can bump its count on the tick edge.
module ms_tick_gen
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_MS = DEF_TICKS_PER_MS
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic zero,
    output logic tick,
    output logic carry
);

    localparam int            PW   = $clog2(TICKS_PER_MS);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_MS - 1);

    logic [PW-1:0] presc_r;
    logic          tick_r;

    assign carry = en & (presc_r == LAST);
    assign tick  = tick_r;

    // Prescaler advance; holds its value while disabled so a resume continues mid-ms.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
            tick_r  <= 1'b0;
        end else if (zero) begin
            presc_r <= '0;
            tick_r  <= 1'b0;
        end else if (carry) begin
            presc_r <= '0;
            tick_r  <= 1'b1;
        end else if (en) begin
            presc_r <= presc_r + PW'(1);
            tick_r  <= 1'b0;
        end else begin
            tick_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edge detection, run/lap/pause FSM, elapsed-ms
// count with sticky wrap flag, and the lap-frozen display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_MS = DEF_TICKS_PER_MS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    output logic [CNT_W-1:0] elapsed,
    output logic [CNT_W-1:0] display,
    output logic             ms_tick,
    output logic             running,
    output logic             lap_active,
    output logic             overflow
);

    if (TICKS_PER_MS < 2) begin : g_bad_ticks
        $fatal(1, "stopwatch_ctrl: TICKS_PER_MS must be >= 2");
    end

    sw_state_t        state_r;
    sw_state_t        state_nxt_s;
    logic             ss_prev_r;
    logic             lap_prev_r;
    logic             clr_prev_r;
    logic             ss_edge_s;
    logic             lap_edge_s;
    logic             clr_edge_s;
    logic             count_en_s;
    logic             presc_zero_s;
    logic             do_clear_s;
    logic             lap_load_s;
    logic             carry_s;
    logic             tick_s;
    logic [CNT_W-1:0] elapsed_r;
    logic [CNT_W-1:0] lap_reg_r;
    logic             overflow_r;

    assign ss_edge_s  = start_stop & ~ss_prev_r;
    assign lap_edge_s = lap & ~lap_prev_r;
    assign clr_edge_s = clear & ~clr_prev_r;
    assign count_en_s = (state_r == RUN) | (state_r == LAP);

    // Button history; also loads during reset so a held button yields no edge afterwards.
    always_ff @(posedge clk) begin
        ss_prev_r  <= start_stop;
        lap_prev_r <= lap;
        clr_prev_r <= clear;
    end

    // Next-state decode; within each state the first valid edge in clear > start_stop > lap wins.
    always_comb begin
        state_nxt_s  = state_r;
        presc_zero_s = 1'b0;
        do_clear_s   = 1'b0;
        lap_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_edge_s) begin
                    state_nxt_s  = RUN;
                    presc_zero_s = 1'b1;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            RUN: begin
                if (ss_edge_s) begin
                    state_nxt_s = PAUSE;
                end else if (lap_edge_s) begin
                    state_nxt_s = LAP;
                    lap_load_s  = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LAP: begin
                if (ss_edge_s) begin
                    state_nxt_s = PAUSE;
                end else if (lap_edge_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LAP;
                end
            end
            PAUSE: begin
                if (clr_edge_s) begin
                    state_nxt_s  = IDLE;
                    do_clear_s   = 1'b1;
                    presc_zero_s = 1'b1;
                end else if (ss_edge_s) begin
                    state_nxt_s  = RUN;
                end else begin
                    state_nxt_s  = PAUSE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    ms_tick_gen #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (count_en_s),
        .zero  (presc_zero_s),
        .tick  (tick_s),
        .carry (carry_s)
    );

    // Elapsed count, lap snapshot (pre-increment value) and sticky wrap flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            elapsed_r  <= '0;
            lap_reg_r  <= '0;
            overflow_r <= 1'b0;
        end else if (do_clear_s) begin
            elapsed_r  <= '0;
            lap_reg_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (carry_s) begin
                elapsed_r <= elapsed_r + CNT_W'(1);
            end
            if (carry_s && (elapsed_r == {CNT_W{1'b1}})) begin
                overflow_r <= 1'b1;
            end
            if (lap_load_s) begin
                lap_reg_r <= elapsed_r;
            end
        end
    end

    assign elapsed    = elapsed_r;
    assign display    = (state_r == LAP) ? lap_reg_r : elapsed_r;
    assign ms_tick    = tick_s;
    assign running    = count_en_s;
    assign lap_active = (state_r == LAP);
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICKS_PER_MS=4 at CNT_W=32 and CNT_W=4.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_stop = 1'b0;
    logic lap = 1'b0;
    logic clear = 1'b0;
    logic ss4 = 1'b0;
    logic lap4 = 1'b0;
    logic clr4 = 1'b0;

    logic [31:0] elapsed, display;
    logic        ms_tick, running, lap_active, overflow;
    logic [3:0]  elapsed4, display4;
    logic        ms_tick4, running4, lap_active4, overflow4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICKS_PER_MS(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .elapsed(elapsed), .display(display), .ms_tick(ms_tick), .running(running),
        .lap_active(lap_active), .overflow(overflow)
    );

    stopwatch_ctrl #(.TICKS_PER_MS(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start_stop(ss4), .lap(lap4), .clear(clr4),
        .elapsed(elapsed4), .display(display4), .ms_tick(ms_tick4), .running(running4),
        .lap_active(lap_active4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        ss4 = 1'b0; lap4 = 1'b0; clr4 = 1'b0;
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Test 1: reset state, then continuous RUN
        do_reset();
        check("rst_elapsed", elapsed, 32'd0);
        check("rst_display", display, 32'd0);
        check("rst_tick", {31'd0, ms_tick}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_lap_active", {31'd0, lap_active}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        start_stop = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            step();
            if (k == 1) start_stop = 1'b0;
            check("t1_tick", {31'd0, ms_tick}, ((k >= 5) && ((k - 5) % 4 == 0)) ? 32'd1 : 32'd0);
            check("t1_elapsed", elapsed, 32'((k - 1) / 4));
            check("t1_running", {31'd0, running}, 32'd1);
        end
        check("t1_elapsed_40", elapsed, 32'd10);

        // Test 2: pause holds count and prescaler
        do_reset();
        start_stop = 1'b1; step(); start_stop = 1'b0;
        run_to(10);
        check("t2_elapsed_pre", elapsed, 32'd2);
        start_stop = 1'b1; step(); start_stop = 1'b0;
        for (int k = 11; k <= 30; k++) begin
            check("t2_pause_elapsed", elapsed, 32'd2);
            check("t2_pause_tick", {31'd0, ms_tick}, 32'd0);
            check("t2_pause_running", {31'd0, running}, 32'd0);
            if (k < 30) step();
        end
        start_stop = 1'b1; step(); start_stop = 1'b0;
        check("t2_resume_running", {31'd0, running}, 32'd1);
        check("t2_resume_elapsed0", elapsed, 32'd2);
        step();
        check("t2_resume_elapsed1", elapsed, 32'd2);
        check("t2_resume_tick1", {31'd0, ms_tick}, 32'd0);
        step();
        check("t2_resume_elapsed2", elapsed, 32'd3);
        check("t2_resume_tick2", {31'd0, ms_tick}, 32'd1);

        // Test 3: lap freezes display, second lap returns to live
        do_reset();
        start_stop = 1'b1; step(); start_stop = 1'b0;
        run_to(22);
        check("t3_elapsed_at_lap", elapsed, 32'd5);
        lap = 1'b1; step(); lap = 1'b0;
        check("t3_lap_active", {31'd0, lap_active}, 32'd1);
        check("t3_running", {31'd0, running}, 32'd1);
        for (int k = 23; k <= 37; k++) begin
            check("t3_display_frozen", display, 32'd5);
            check("t3_elapsed_live", elapsed, 32'((k - 1) / 4));
            if (k < 37) step();
        end
        lap = 1'b1; step(); lap = 1'b0;
        check("t3_lap_off", {31'd0, lap_active}, 32'd0);
        check("t3_display_live", display, 32'd9);
        run_to(41);
        check("t3_display_track", display, 32'd10);
        check("t3_elapsed_track", elapsed, 32'd10);

        // Test 4: CNT_W=4 wrap, pause, clear
        do_reset();
        ss4 = 1'b1; step(); ss4 = 1'b0;
        run_to(64);
        check("t4_elapsed_15", {28'd0, elapsed4}, 32'd15);
        check("t4_ovf_before", {31'd0, overflow4}, 32'd0);
        step();
        check("t4_elapsed_wrap", {28'd0, elapsed4}, 32'd0);
        check("t4_ovf_set", {31'd0, overflow4}, 32'd1);
        check("t4_tick_wrap", {31'd0, ms_tick4}, 32'd1);
        run_to(69);
        check("t4_elapsed_after", {28'd0, elapsed4}, 32'd1);
        check("t4_ovf_sticky", {31'd0, overflow4}, 32'd1);
        ss4 = 1'b1; step(); ss4 = 1'b0;
        check("t4_paused", {31'd0, running4}, 32'd0);
        check("t4_pause_display", {28'd0, display4}, 32'd1);
        clr4 = 1'b1; step(); clr4 = 1'b0;
        check("t4_clr_elapsed", {28'd0, elapsed4}, 32'd0);
        check("t4_clr_display", {28'd0, display4}, 32'd0);
        check("t4_clr_ovf", {31'd0, overflow4}, 32'd0);
        check("t4_clr_running", {31'd0, running4}, 32'd0);
        step(); step();
        check("t4_idle_hold", {31'd0, running4}, 32'd0);
        check("t4_idle_lap", {31'd0, lap_active4}, 32'd0);

        // Test 5: clear ignored in RUN; clear beats start_stop in PAUSE
        do_reset();
        start_stop = 1'b1; step(); start_stop = 1'b0;
        run_to(6);
        clear = 1'b1; step(); clear = 1'b0;
        check("t5_run_clear_running", {31'd0, running}, 32'd1);
        check("t5_run_clear_elapsed", elapsed, 32'd1);
        run_to(9);
        check("t5_still_counting", elapsed, 32'd2);
        check("t5_tick", {31'd0, ms_tick}, 32'd1);
        run_to(10);
        start_stop = 1'b1; step(); start_stop = 1'b0;
        check("t5_paused", {31'd0, running}, 32'd0);
        check("t5_pause_elapsed", elapsed, 32'd2);
        step();
        clear = 1'b1; start_stop = 1'b1; step(); clear = 1'b0; start_stop = 1'b0;
        check("t5_both_running", {31'd0, running}, 32'd0);
        check("t5_both_elapsed", elapsed, 32'd0);
        check("t5_both_display", display, 32'd0);
        check("t5_both_overflow", {31'd0, overflow}, 32'd0);
        step();
        check("t5_idle_hold", {31'd0, running}, 32'd0);
        step();
        start_stop = 1'b1; step(); start_stop = 1'b0;
        check("t5_restart", {31'd0, running}, 32'd1);
        run_to(19);
        check("t5_restart_elapsed0", elapsed, 32'd0);
        step();
        check("t5_restart_elapsed1", elapsed, 32'd1);
        check("t5_restart_tick", {31'd0, ms_tick}, 32'd1);

        // Test 6: reset mid-RUN with start_stop held high
        do_reset();
        start_stop = 1'b1; step();
        run_to(10);
        check("t6_pre_elapsed", elapsed, 32'd2);
        reset = 1'b1; step(); reset = 1'b0;
        check("t6_rst_running", {31'd0, running}, 32'd0);
        check("t6_rst_elapsed", elapsed, 32'd0);
        check("t6_rst_tick", {31'd0, ms_tick}, 32'd0);
        for (int k = 12; k <= 16; k++) begin
            step();
            check("t6_no_spurious_run", {31'd0, running}, 32'd0);
            check("t6_held_elapsed", elapsed, 32'd0);
        end
        start_stop = 1'b0; step();
        start_stop = 1'b1; step(); start_stop = 1'b0;
        check("t6_fresh_run", {31'd0, running}, 32'd1);
        run_to(21);
        check("t6_fresh_elapsed0", elapsed, 32'd0);
        step();
        check("t6_fresh_elapsed1", elapsed, 32'd1);
        check("t6_fresh_tick", {31'd0, ms_tick}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences a millisecond count datapath as a stopwatch. It has start/stop, lap and clear controls.
- Generates the 1 ms tick from the system clock with an internal prescaler.
- Holds the elapsed-ms count and a lap-frozen display value.
- Sits between the debounced button inputs and the display/segment driver logic.

Parameters:
TICKS_PER_MS, 1000, clk cycles per ms tick; must be >= 2.
CNT_W, 32, width of the elapsed and display counts.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
start_stop  input  1  debounced level; rising edge toggles run/pause.
lap  input  1  debounced level; rising edge freezes or unfreezes the display.
clear  input  1  debounced level; rising edge zeroes the count when paused.
elapsed  output  CNT_W  live ms count.
display  output  CNT_W  value for the display: live count, or the latched lap value.
ms_tick  output  1  one-cycle pulse, coincident with each elapsed increment.
running  output  1  high in RUN and LAP.
lap_active  output  1  high in LAP.
overflow  output  1  sticky; set when elapsed wraps.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; elapsed, display, lap_reg, prescaler, ms_tick, overflow = 0.
  - Edge-detect history registers load the current input values, so a button held through reset produces no edge.
- Edge detect:
  - edge_x = x & ~x_prev, evaluated combinationally in the cycle x first reads high.
  - x_prev is registered every cycle.
  - A level held high gives exactly one edge.
- Simultaneous-edge priority: clear > start_stop > lap. Only the highest-priority edge that is valid in the current state acts; the others are discarded.
- States:
  - IDLE: start_stop -> RUN (prescaler=0). lap and clear ignored.
  - RUN: start_stop -> PAUSE. lap -> LAP with lap_reg <= elapsed (the pre-update value of that cycle). clear ignored.
  - LAP: start_stop -> PAUSE (display returns to live). lap -> RUN. clear ignored.
  - PAUSE: start_stop -> RUN (prescaler resumes from its held value, not zeroed). clear -> IDLE, zeroing elapsed, prescaler, overflow and lap_reg. lap ignored.
- Counting:
  - Active only in cycles where the registered state is RUN or LAP.
  - The transition cycle itself counts under the old state.
  - In each such cycle: if prescaler == TICKS_PER_MS-1, then prescaler <= 0, elapsed <= elapsed+1 and ms_tick <= 1. Otherwise prescaler <= prescaler+1 and ms_tick <= 0.
  - ms_tick = 0 in IDLE/PAUSE.
- Latency:
  - start_stop rises in cycle N; state=RUN from N+1.
  - First ms_tick and elapsed=1 appear at N+TICKS_PER_MS+1, then every TICKS_PER_MS cycles.
- Wrap: elapsed increments modulo 2^CNT_W. On the all-ones->0 increment, overflow <= 1; it stays set until clear (PAUSE->IDLE) or reset.
- Display:
  - LAP: display = lap_reg.
  - Otherwise display = elapsed, including in the same cycle as an increment.
  - display is a combinational mux of registers.
- Prescaler width = $clog2(TICKS_PER_MS).
- Out-of-range TICKS_PER_MS (< 2) is a fatal elaboration error.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t.
  - Default constants DEF_TICKS_PER_MS=1000 and DEF_CNT_W=32.
- One sub-module, ms_tick_gen: prescaler plus ms_tick.
  - Ports: clk, reset, en, zero.
  - Outputs: tick.
  - The FSM, edge detect, elapsed, lap and overflow logic stay in stopwatch_ctrl.

Test Plan:
Unless noted, TICKS_PER_MS=4 and CNT_W=32.
1. Reset, start_stop edge at cycle 0, hold RUN 40 cycles -> ms_tick every 4th cycle starting cycle 5; elapsed=10 after 40 RUN cycles; running=1.
2. RUN 10 cycles (elapsed=2, prescaler=2), then start_stop edge -> PAUSE for 20 cycles -> elapsed holds 2, ms_tick=0. Resume -> elapsed=3 after exactly 2 RUN cycles (prescaler not reset).
3. Lap edge at elapsed=5 -> lap_active=1, display holds 5 while elapsed reaches 9. Lap edge again -> display=9, tracking live.
4. CNT_W=4: run 64 cycles -> elapsed goes 15->0 with overflow=1. Pause, then clear edge -> IDLE with elapsed=0, display=0, overflow=0.
5. clear edge in RUN -> ignored, counting continues. In PAUSE, clear and start_stop rising in the same cycle -> IDLE, all zero.
6. Reset asserted mid-RUN with start_stop held high through reset release -> IDLE, elapsed=0, no spurious RUN entry. The next fresh rising edge -> RUN.
